alu_seq_fsm: RTL and testbench
==============================

# alu_seq_fsm

Parametrised sequenced-ALU controller: loads two operands over a valid/ready input stream, applies a per-transaction selectable chain of ADD, SUB and SHIFT to the first operand, then emits two results over a valid/ready output stream. It sits between an operand source and a result sink as the next-generation, width-generic, flow-controlled version of the team's fixed 8-bit load/add/sub/shift/store sequencer.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- SHIFT_AMT, 1, left-shift distance applied in SHIFT state (1..WIDTH-1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin transaction; sampled only in IDLE
- mode  in  3  op enables {shift_en, sub_en, add_en}; latched when start is accepted
- abort  in  1  synchronous abort, any state
- in_valid  in  1  operand valid
- in_data  in  WIDTH  operand
- in_ready  out  1  high in LOAD1/LOAD2
- out_valid  out  1  high in STORE1/STORE2
- out_data  out  WIDTH  result (reg1 in STORE1, reg2 in STORE2)
- out_last  out  1  high in STORE2
- out_ready  in  1  sink accepts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after STORE2 handshake

## Operation
- States (one-hot): IDLE, LOAD1, LOAD2, ADD, SUB, SHIFT, STORE1, STORE2.
- IDLE: start → LOAD1, latch mode. start while busy ignored.
- LOAD1: on in_valid, reg1 ← in_data, → LOAD2; else hold. LOAD2: likewise into reg2, → first enabled op state.
- Op chain order fixed ADD → SUB → SHIFT; disabled ops skipped with no cycle spent; mode=000 goes LOAD2 → STORE1.
- ADD: reg1 ← reg1 + reg2. SUB: reg1 ← reg1 − reg2. SHIFT: reg1 ← reg1 << SHIFT_AMT. One cycle each; all WIDTH-bit unsigned, modulo 2^WIDTH.
- STORE1: out_data = reg1; on out_valid&out_ready → STORE2. STORE2: out_data = reg2, out_last=1; on handshake → IDLE, done=1 next cycle.
- abort: next state IDLE, no done, reg1/reg2 retain values; abort beats start, in_valid, out_ready in the same cycle.
- in_valid outside LOAD states ignored; operand not consumed.
- Illegal state (not one-hot) → IDLE next cycle.
- Reset: state IDLE, reg1=reg2=0, mode=0, done=0; hence in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0. Reset mid-transaction discards it, no done.

## Timing
- All outputs decoded from flops only; no combinational input-to-output path.
- mode=111, in_valid and out_ready held high, start sampled at cycle 0: LOAD1 c1, LOAD2 c2, ADD c3, SUB c4, SHIFT c5, STORE1 c6, STORE2 c7, done=1 and IDLE c8. New start accepted at c8.
- Each disabled op removes one cycle; mode=000 gives done at c5.
- Each stalled cycle (in_valid=0 in LOAD, out_ready=0 in STORE) adds one cycle; out_data stable while out_valid && !out_ready.
- done is high exactly one cycle; never asserted after abort or reset.

## Configuration
- ALU_SEQ_SAT_EN defined: unsigned saturation: ADD clamps to 2^WIDTH−1 on carry; SUB clamps to 0 on borrow; SHIFT clamps to 2^WIDTH−1 if any nonzero bit is shifted out.
- Undefined: plain modulo wrap as above. Control timing identical in both builds.

## Structure
- Package alu_seq_pkg: one-hot state localparams/enum (8 bits), mode bit indices (MODE_ADD=0, MODE_SUB=1, MODE_SHIFT=2), state count.
- Sub-module alu_seq_dp: reg1/reg2 registers and ADD/SUB/SHIFT (saturation) logic, controlled by state from the top-level FSM.

## Test plan
- WIDTH=8, mode=111, a=0x05, b=0x03, no stalls → out 0x0A (not last) at c6, 0x03 (last) at c7, done at c8.
- mode=001, a=0xF0, b=0x20 → first result 0x10; with ALU_SEQ_SAT_EN 0xFF. mode=010, a=0x02, b=0x05 → 0xFD / SAT 0x00.
- mode=000, a=0x81, b=0x7E → results 0x81, 0x7E, done at c5; mode=100, a=0x81, SAT build → 0xFF.
- in_valid low 3 cycles in LOAD1 and out_ready low 2 cycles in STORE1 → done delayed 5 cycles; out_data held 0x0A throughout stall.
- abort in SUB → IDLE next cycle, no out_valid, no done; start in same cycle as abort in IDLE → ignored.
- rst_n asserted in STORE1 → all outputs 0 immediately; start ignored while busy (second start in ADD has no effect).

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - one-hot state encoding, mode bit indices and op-chain helper for alu_seq_fsm
package alu_seq_pkg;

  localparam int NUM_STATES = 8;
  localparam int MODE_ADD   = 0;
  localparam int MODE_SUB   = 1;
  localparam int MODE_SHIFT = 2;

  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE   = 8'b0000_0001,
    ST_LOAD1  = 8'b0000_0010,
    ST_LOAD2  = 8'b0000_0100,
    ST_ADD    = 8'b0000_1000,
    ST_SUB    = 8'b0001_0000,
    ST_SHIFT  = 8'b0010_0000,
    ST_STORE1 = 8'b0100_0000,
    ST_STORE2 = 8'b1000_0000
  } state_t;

  // First enabled op among the remaining enables, falling through to STORE1.
  function automatic state_t first_op(input logic [2:0] m);
    if (m[MODE_ADD])   return ST_ADD;
    if (m[MODE_SUB])   return ST_SUB;
    if (m[MODE_SHIFT]) return ST_SHIFT;
    return ST_STORE1;
  endfunction

endpackage

// File: rtl/alu_seq_dp.sv
// rtl/alu_seq_dp.sv - operand registers and ADD/SUB/SHIFT logic for alu_seq_fsm
// ALU_SEQ_SAT_EN selects unsigned saturation instead of modulo wrap.
module alu_seq_dp
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SHIFT_AMT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld1,
  input  logic             ld2,
  input  logic             op_add,
  input  logic             op_sub,
  input  logic             op_shift,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2
);

  logic [WIDTH:0]           add_full;
  logic [WIDTH:0]           sub_full;
  logic [WIDTH+SHIFT_AMT-1:0] shl_full;
  logic [WIDTH-1:0]         add_res;
  logic [WIDTH-1:0]         sub_res;
  logic [WIDTH-1:0]         shl_res;

  // The extra top bit carries the carry, borrow or shifted-out bits.
  assign add_full = {1'b0, reg1} + {1'b0, reg2};
  assign sub_full = {1'b0, reg1} - {1'b0, reg2};
  assign shl_full = {{SHIFT_AMT{1'b0}}, reg1} << SHIFT_AMT;

`ifdef ALU_SEQ_SAT_EN
  assign add_res = add_full[WIDTH] ? '1 : add_full[WIDTH-1:0];
  assign sub_res = sub_full[WIDTH] ? '0 : sub_full[WIDTH-1:0];
  assign shl_res = (|shl_full[WIDTH+SHIFT_AMT-1:WIDTH]) ? '1 : shl_full[WIDTH-1:0];
`else
  logic unused_ovf;
  assign unused_ovf = ^{add_full[WIDTH], sub_full[WIDTH], shl_full[WIDTH+SHIFT_AMT-1:WIDTH]};
  assign add_res = add_full[WIDTH-1:0];
  assign sub_res = sub_full[WIDTH-1:0];
  assign shl_res = shl_full[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg1 <= '0;
      reg2 <= '0;
    end else begin
      if (ld1)           reg1 <= in_data;
      else if (op_add)   reg1 <= add_res;
      else if (op_sub)   reg1 <= sub_res;
      else if (op_shift) reg1 <= shl_res;
      if (ld2)           reg2 <= in_data;
    end
  end

endmodule

// File: rtl/alu_seq_fsm.sv
// rtl/alu_seq_fsm.sv - sequenced-ALU controller: load two operands, run ADD/SUB/SHIFT chain, emit two results
// ALU_SEQ_SAT_EN (in alu_seq_dp) switches the datapath to unsigned saturation.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SHIFT_AMT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [2:0]       mode_r;
  logic [WIDTH-1:0] reg1;
  logic [WIDTH-1:0] reg2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_r <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:   if (start) begin state <= ST_LOAD1; mode_r <= mode; end
          ST_LOAD1:  if (in_valid) state <= ST_LOAD2;
          ST_LOAD2:  if (in_valid) state <= first_op(mode_r);
          ST_ADD:    state <= first_op(mode_r & 3'b110);
          ST_SUB:    state <= first_op(mode_r & 3'b100);
          ST_SHIFT:  state <= ST_STORE1;
          ST_STORE1: if (out_ready) state <= ST_STORE2;
          ST_STORE2: if (out_ready) begin state <= ST_IDLE; done <= 1'b1; end
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  // Outputs are pure decodes of the state and operand flops.
  assign in_ready  = (state == ST_LOAD1) || (state == ST_LOAD2);
  assign out_valid = (state == ST_STORE1) || (state == ST_STORE2);
  assign out_last  = (state == ST_STORE2);
  assign busy      = (state != ST_IDLE);
  assign out_data  = (state == ST_STORE1) ? reg1 :
                     (state == ST_STORE2) ? reg2 : '0;

  alu_seq_dp #(.WIDTH(WIDTH), .SHIFT_AMT(SHIFT_AMT)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld1      ((state == ST_LOAD1) && in_valid && !abort),
    .ld2      ((state == ST_LOAD2) && in_valid && !abort),
    .op_add   ((state == ST_ADD) && !abort),
    .op_sub   ((state == ST_SUB) && !abort),
    .op_shift ((state == ST_SHIFT) && !abort),
    .in_data  (in_data),
    .reg1     (reg1),
    .reg2     (reg2)
  );

endmodule

// File: tb/tb_alu_seq_fsm.sv
// tb/tb_alu_seq_fsm.sv - scoreboard bench for alu_seq_fsm, WIDTH=8, SHIFT_AMT=1
module tb_alu_seq_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb_q[$];

  alu_seq_fsm #(.WIDTH(8), .SHIFT_AMT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    r = a;
    if (m[0]) begin
      t = {1'b0, r} + {1'b0, b};
`ifdef ALU_SEQ_SAT_EN
      r = t[8] ? 8'hFF : t[7:0];
`else
      r = t[7:0];
`endif
    end
    if (m[1]) begin
`ifdef ALU_SEQ_SAT_EN
      r = (r < b) ? 8'h00 : r - b;
`else
      r = r - b;
`endif
    end
    if (m[2]) begin
`ifdef ALU_SEQ_SAT_EN
      r = r[7] ? 8'hFF : {r[6:0], 1'b0};
`else
      r = {r[6:0], 1'b0};
`endif
    end
    return r;
  endfunction

  // cut_at > 0 ends the transaction by abort (is_rst=0) or reset (is_rst=1) at that cycle.
  task automatic run_txn(input string tag, input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_r1, input int in_st, input int out_st, input int exp_lat,
                         input int cut_at, input bit is_rst, input int restart_at);
    int cyc;
    int n_in;
    int ist;
    int ost;
    bit seen_done;
    logic [8:0] e;
    cyc = 0; n_in = 0; ist = in_st; ost = out_st; seen_done = 0;
    if (cut_at == 0) begin
      sb_q.push_back({1'b0, exp_r1});
      sb_q.push_back({1'b1, b});
    end
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    while (cyc < 40 && !seen_done) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      abort = 1'b0;
      if (cut_at > 0 && cyc >= cut_at) begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (cyc == cut_at) begin
          if (is_rst) begin
            rst_n = 1'b0;
            #1;
            check({tag, " rst out_valid"}, out_valid, 0);
            check({tag, " rst out_data"}, out_data, 0);
            check({tag, " rst busy"}, busy, 0);
            check({tag, " rst in_ready"}, in_ready, 0);
            check({tag, " rst out_last"}, out_last, 0);
          end else begin
            abort = 1'b1;
          end
        end else begin
          if (cyc == cut_at + 2) rst_n = 1'b1;
          check({tag, " cut busy"}, busy, 0);
          check({tag, " cut out_valid"}, out_valid, 0);
          check({tag, " cut done"}, done, 0);
          if (cyc >= cut_at + 5) break;
        end
      end else if (done) begin
        seen_done = 1;
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " busy at done"}, busy, 0);
      end else begin
        if (in_ready) begin
          if (n_in == 0 && ist > 0) begin
            in_valid = 1'b0;
            ist--;
          end else begin
            in_valid = 1'b1;
            in_data  = (n_in == 0) ? a : b;
            n_in++;
          end
        end else begin
          in_valid = 1'b0;
        end
        if (out_valid) begin
          if (!out_last && ost > 0) begin
            out_ready = 1'b0;
            ost--;
            check({tag, " held data"}, out_data, exp_r1);
          end else begin
            out_ready = 1'b1;
            if (sb_q.size() == 0) begin
              check({tag, " unexpected output"}, 1, 0);
            end else begin
              e = sb_q.pop_front();
              check({tag, " data"}, out_data, e[7:0]);
              check({tag, " last"}, out_last, e[8]);
            end
          end
        end else begin
          out_ready = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    if (cut_at == 0) begin
      if (!seen_done) check({tag, " timeout"}, 0, 1);
      @(negedge clk);
      check({tag, " done width"}, done, 0);
    end
  endtask

  initial begin
    logic [2:0] rm;
    logic [7:0] ra;
    logic [7:0] rb;
    #12;
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset busy", busy, 0);
    check("reset out_data", out_data, 0);
    check("reset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ALU_SEQ_SAT_EN
    run_txn("m111", 3'b111, 8'h05, 8'h03, 8'h0A, 0, 0, 8, 0, 0, 0);
    run_txn("m001", 3'b001, 8'hF0, 8'h20, 8'hFF, 0, 0, 6, 0, 0, 0);
    run_txn("m010", 3'b010, 8'h02, 8'h05, 8'h00, 0, 0, 6, 0, 0, 0);
    run_txn("m000", 3'b000, 8'h81, 8'h7E, 8'h81, 0, 0, 5, 0, 0, 0);
    run_txn("m100", 3'b100, 8'h81, 8'h55, 8'hFF, 0, 0, 6, 0, 0, 0);
`else
    run_txn("m111", 3'b111, 8'h05, 8'h03, 8'h0A, 0, 0, 8, 0, 0, 0);
    run_txn("m001", 3'b001, 8'hF0, 8'h20, 8'h10, 0, 0, 6, 0, 0, 0);
    run_txn("m010", 3'b010, 8'h02, 8'h05, 8'hFD, 0, 0, 6, 0, 0, 0);
    run_txn("m000", 3'b000, 8'h81, 8'h7E, 8'h81, 0, 0, 5, 0, 0, 0);
    run_txn("m100", 3'b100, 8'h81, 8'h55, 8'h02, 0, 0, 6, 0, 0, 0);
`endif
    run_txn("stall", 3'b111, 8'h05, 8'h03, 8'h0A, 3, 2, 13, 0, 0, 0);
    run_txn("restart in ADD", 3'b111, 8'h05, 8'h03, 8'h0A, 0, 0, 8, 0, 0, 3);
    run_txn("abort in SUB", 3'b111, 8'h05, 8'h03, 8'h0A, 0, 0, 0, 4, 0, 0);
    run_txn("reset in STORE1", 3'b111, 8'h05, 8'h03, 8'h0A, 0, 0, 0, 6, 1, 0);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start with abort busy", busy, 0);
    check("start with abort in_ready", in_ready, 0);

    for (int i = 0; i < 6; i++) begin
      rm = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_txn("random", rm, ra, rb, model(rm, ra, rb), i % 3, i % 2, 5 + $countones(rm) + i % 3 + i % 2,
              0, 0, 0);
    end

    check("scoreboard drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
